// File: rtl/bu_mul_stage.sv
// -----------------------------------------------------------------------------
// bu_mul_stage
//   Pipelined multiply front end of the butterfly unit. Each accepted
//   coefficient/twiddle pair (a, b) plus a sideband tag travels through two
//   register stages:
//     S1 : registers a, b and the tag
//     S2 : registers the full 32-bit unsigned product a*b and the tag
//   The S2 registers drive c / out_tag / out_valid directly, so this stage
//   can feed barrett_reduction's 32-bit input without any input-to-output
//   combinational path. Backpressure is elastic: an empty S2 always fills
//   from S1, and each stage holds while its successor cannot take data.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand pair valid
//   in_ready   : stage can accept an operand pair this cycle
//   a, b       : 16-bit coefficient / twiddle operands
//   in_tag     : sideband tag travelling with the pair
//   out_valid  : product valid
//   out_ready  : downstream consumer accepts the product
//   c          : product a*b, zero-extended to 32 bits
//   out_tag    : tag belonging to the product on c
//   range_err  : sticky flag, an accepted operand was >= Q
//   prod_cnt   : number of products handed off, wraps at 2^16
// -----------------------------------------------------------------------------
module bu_mul_stage #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      c,
  output logic [TAG_W-1:0] out_tag,
  output logic             range_err,
  output logic [15:0]      prod_cnt
);

  localparam logic [31:0] Q_W = 32'(Q);

  // True when an operand is not a canonical residue mod Q.
  function automatic logic not_canonical(input logic [15:0] v);
    return (32'(v) >= Q_W);
  endfunction

  logic             s1_valid_r;
  logic [15:0]      s1_a_r;
  logic [15:0]      s1_b_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic             s2_valid_r;
  logic [31:0]      s2_c_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             range_err_r;
  logic [15:0]      prod_cnt_r;

  logic s2_adv_s;
  logic s1_adv_s;
  logic in_fire_s;
  logic out_fire_s;
  logic op_bad_s;

  // Handshake decode: advance enables depend only on valid bits and
  // out_ready, never on in_valid.
  always_comb begin
    s2_adv_s   = ~s2_valid_r | out_ready;
    s1_adv_s   = ~s1_valid_r | s2_adv_s;
    in_fire_s  = in_valid & s1_adv_s;
    out_fire_s = s2_valid_r & out_ready;
    op_bad_s   = not_canonical(a) | not_canonical(b);
  end

  // Valid bits for both stages; cleared on reset so no stale product leaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= in_valid;
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end
    end
  end

  // S1 operand and tag capture; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      s1_a_r   <= a;
      s1_b_r   <= b;
      s1_tag_r <= in_tag;
    end
  end

  // S2 product and tag; zeroed on reset because they are visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_c_r   <= 32'd0;
      s2_tag_r <= '0;
    end else if (s2_adv_s && s1_valid_r) begin
      s2_c_r   <= 32'(s1_a_r) * 32'(s1_b_r);
      s2_tag_r <= s1_tag_r;
    end
  end

  // Sticky range flag, set on acceptance of any non-canonical operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_r <= 1'b0;
    end else if (in_fire_s && op_bad_s) begin
      range_err_r <= 1'b1;
    end
  end

  // Handoff counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_cnt_r <= 16'd0;
    end else if (out_fire_s) begin
      prod_cnt_r <= prod_cnt_r + 16'd1;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;
  assign c         = s2_c_r;
  assign out_tag   = s2_tag_r;
  assign range_err = range_err_r;
  assign prod_cnt  = prod_cnt_r;

endmodule

// File: tb/tb_bu_mul_stage.sv
// -----------------------------------------------------------------------------
// tb_bu_mul_stage
//   Scoreboard bench for bu_mul_stage. The driver issues operand pairs; a
//   monitor on the falling edge records every accepted pair's expected
//   product (plain integer a*b) and tag into queues, pops and compares on
//   every output handoff, and tracks the expected sticky error flag and the
//   handoff count.
// -----------------------------------------------------------------------------
module tb_bu_mul_stage;
  localparam int Q     = 3329;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      a = 16'd0;
  logic [15:0]      b = 16'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      c;
  logic [TAG_W-1:0] out_tag;
  logic             range_err;
  logic [15:0]      prod_cnt;

  bu_mul_stage #(.Q(Q), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .out_tag(out_tag),
    .range_err(range_err), .prod_cnt(prod_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]      sb_c[$];
  logic [TAG_W-1:0] sb_t[$];
  logic             m_err = 1'b0;
  logic [15:0]      m_cnt = 16'd0;
  bit               mon_en = 1'b0;
  bit               stream_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("range_err", {63'd0, range_err}, {63'd0, m_err});
      chk("prod_cnt", {48'd0, prod_cnt}, {48'd0, m_cnt});
      if (stream_chk) chk("in_ready_stream", {63'd0, in_ready}, 64'd1);
      if (rst) begin
        sb_c.delete();
        sb_t.delete();
        m_err = 1'b0;
        m_cnt = 16'd0;
      end else begin
        if (in_valid && in_ready) begin
          longint pa;
          longint pb;
          pa = longint'(a);
          pb = longint'(b);
          sb_c.push_back(32'(pa * pb));
          sb_t.push_back(in_tag);
          if (pa >= Q || pb >= Q) m_err = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (sb_c.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got c=0x%0h with empty scoreboard at %0t", c, $time);
          end else begin
            logic [31:0]      ec;
            logic [TAG_W-1:0] et;
            ec = sb_c.pop_front();
            et = sb_t.pop_front();
            chk("c", {32'd0, c}, {32'd0, ec});
            chk("out_tag", {56'd0, out_tag}, {56'd0, et});
          end
          m_cnt = m_cnt + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until it is accepted (bounded); in_valid stays 1.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic [TAG_W-1:0] vt);
    bit ok;
    a = va; b = vb; in_tag = vt; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: pair (%0d,%0d) never accepted", va, vb);
    end
  endtask

  // Wait (bounded) until the scoreboard is empty.
  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb_c.size() != 0; i++) tick();
    chk(name, 64'(sb_c.size()), 64'd0);
  endtask

  initial begin
    int cnt0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_c", {32'd0, c}, 64'd0);
    chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;
    tick();

    // Single max in-range pair with latency check.
    out_ready = 1'b1;
    a = 16'd3328; b = 16'd3328; in_tag = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("lat_edge2_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_c", {32'd0, c}, 64'h0000_0000_00A9_0000);
    chk("lat_tag", {56'd0, out_tag}, 64'h5A);
    tick();
    @(negedge clk);
    chk("single_cnt", {48'd0, prod_cnt}, 64'd1);
    tick();

    // Random in-range streaming.
    cnt0 = int'(prod_cnt);
    stream_chk = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1)), 8'($urandom));
    in_valid = 1'b0;
    stream_chk = 1'b0;
    drain("stream_drain");
    chk("stream_cnt", {48'd0, prod_cnt}, 64'((cnt0 + 1000) % 65536));

    // Backpressure: two entries held, third pair stalled.
    out_ready = 1'b0;
    send(16'd2, 16'd3, 8'h01);
    send(16'd4, 16'd5, 8'h02);
    a = 16'd6; b = 16'd7; in_tag = 8'h03; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_c_hold", {32'd0, c}, 64'd6);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    send(16'd6, 16'd7, 8'h03);
    in_valid = 1'b0;
    drain("bp_drain");

    // Bubble collapse: lone pair reaches S2 with out_ready low.
    out_ready = 1'b0;
    send(16'd100, 16'd200, 8'h44);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bub_in_ready", {63'd0, in_ready}, 64'd1);
      if (i >= 1) begin
        chk("bub_valid", {63'd0, out_valid}, 64'd1);
        chk("bub_c", {32'd0, c}, 64'd20000);
      end
      tick();
    end
    out_ready = 1'b1;
    drain("bub_drain");

    // Range error: out-of-range pair still multiplied, flag sticky.
    send(16'd3329, 16'd1, 8'h77);
    in_valid = 1'b0;
    drain("rng_drain");
    send(16'd10, 16'd11, 8'h78);
    in_valid = 1'b0;
    drain("rng_drain2");
    @(negedge clk);
    chk("rng_sticky", {63'd0, range_err}, 64'd1);
    send(16'hFFFF, 16'hFFFF, 8'h79);
    in_valid = 1'b0;
    drain("rng_max_drain");

    // Mid-operation reset with two pairs in flight.
    out_ready = 1'b0;
    send(16'd9, 16'd9, 8'h90);
    send(16'd8, 16'd8, 8'h91);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_c", {32'd0, c}, 64'd0);
    chk("mrst_err", {63'd0, range_err}, 64'd0);
    chk("mrst_cnt", {48'd0, prod_cnt}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_no_stale", {63'd0, out_valid}, 64'd0);
      tick();
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
